pot_ramp_seq: RTL
=================

// Module: pot_ramp_seq
// PURPOSE
//   Upstream sequencer for the MCP41HVX1 SPI potentiometer controller. It accepts a wiper
//   target from the PCI register side and walks the wiper to it in bounded steps with a
//   programmable dwell between writes. Each step is one single-word write through the SPI
//   controller's send/busy/ok handshake. A direct (non-ramped) jump mode and a watchdog on
//   lost completions are included.
// PARAMETERS
//   STEP     1     wiper codes moved per SPI write in ramp mode (1..MAX_CODE)
//   DWELL    4000  clk cycles to wait after a completed write before the next step (>=1)
//   MAX_CODE 256   full-scale wiper code; targets above it are clamped to MAX_CODE
//   TIMEOUT  8191  clk cycles to wait for pot_ok after pot_send before flagging an error
// PORTS
//   clk         in   1  system clock
//   rst_        in   1  asynchronous active-low reset
//   tgt_wr      in   1  one-cycle strobe: load tgt_data as the new target
//   tgt_data    in   9  requested wiper code
//   ramp_en     in   1  1 = step toward target; 0 = single direct write of target
//   pot_dat     out  9  code presented to the SPI controller data input
//   pot_send    out  1  one-cycle write request to the SPI controller
//   pot_busy    in   1  SPI controller busy
//   pot_ok      in   1  SPI controller end-of-write strobe
//   cur_val     out  9  last code confirmed written (updated on pot_ok)
//   ramp_active out  1  1 while cur_val != target or a write is in flight
//   err_tmo     out  1  sticky: a write got no pot_ok within TIMEOUT; cleared by tgt_wr
// BEHAVIOUR
//   Reset: all outputs are 0. target, pending code, dwell and timeout counters are 0.
//     The FSM is in IDLE. The reset is asynchronous, and the release is used synchronously.
//   tgt_wr: target <= min(tgt_data, MAX_CODE) at the next clk edge, in any state.
//     A transfer already in flight is not aborted.
//   FSM states: IDLE -> ISSUE -> WAIT_OK -> DWELL -> IDLE.
//   IDLE:
//     - If target != cur_val and pot_busy = 0, compute nxt and go to ISSUE.
//     - ramp_en = 1: nxt = cur_val +/- STEP toward target, clamped so it never passes target.
//     - ramp_en = 0: nxt = target.
//     - Use 10-bit intermediate arithmetic. There is no wrap below 0 or above MAX_CODE.
//   ISSUE:
//     - pot_dat <= nxt. pot_dat is held stable until the next ISSUE.
//     - pot_send is high for exactly 1 cycle.
//     - Clear the timeout counter, then go to WAIT_OK.
//   WAIT_OK:
//     - pot_ok high: cur_val <= pot_dat, go to DWELL.
//     - Else the timeout counter counts. When it reaches TIMEOUT: err_tmo <= 1, cur_val is
//       unchanged, go to IDLE. The step is retried.
//     - pot_ok outside WAIT_OK is ignored. This covers the spurious ok pulse the SPI
//       controller emits just after reset release.
//   DWELL:
//     - Count DWELL cycles, then go to IDLE.
//     - ramp_en = 0 skips DWELL (exactly 1 cycle is spent in it).
//   pot_send spacing: consecutive pot_send pulses are never closer than the DWELL + 3 cycles
//     of a ramp step. pot_send is never asserted while pot_busy = 1.
//   ramp_active = (state != IDLE) | (target != cur_val).
//   Simultaneous tgt_wr and pot_ok: both take effect. cur_val updates, and the new target is
//     used from the next IDLE decision.
//   tgt_wr equal to cur_val while idle: no write is issued.
//   Reset mid-transfer: the FSM returns to IDLE. The downstream SPI transfer is reset
//     by the shared rst_.
// TESTING
//   1. Reset, wait 4 cycles. Expect: pot_ok glitch ignored; pot_send=0, cur_val=0,
//      ramp_active=0.
//   2. ramp_en=1, STEP=1, DWELL=16, tgt_data=5. Expect: 5 pot_send pulses with pot_dat
//      1,2,3,4,5, >=16 cycles apart; final cur_val=5, ramp_active=0.
//   3. ramp_en=1, STEP=4, from cur_val=10 to tgt=1. Expect: pot_dat 6, 2, 1 (clamped);
//      tgt=300 gives a target of 256.
//   4. ramp_en=0, tgt=200 from 0. Expect: a single pot_send with pot_dat=200, cur_val=200
//      after pot_ok.
//   5. Write tgt=50 mid-ramp toward 100 while at cur_val=60, during WAIT_OK. Expect: the
//      in-flight write completes, then steps descend toward 50.
//   6. Model withholds pot_ok. Expect: err_tmo=1 after TIMEOUT cycles and a retry write of
//      the same code; the next tgt_wr clears err_tmo.

Source files
------------

// File: rtl/pot_ramp_seq.sv
// pot_ramp_seq
//   Upstream sequencer for the MCP41HVX1 SPI potentiometer controller. It takes a
//   wiper target from the register side and walks the wiper there. Each step is one
//   single-word write through the SPI controller's send/busy/ok handshake, and a
//   programmable dwell follows every completed ramp step. A direct jump mode skips
//   the stepping. A watchdog flags writes that never receive a completion.
//
// Parameters
//   STEP     wiper codes moved per write in ramp mode (1..MAX_CODE)
//   DWELL    clk cycles to wait after a completed ramp write (>=1)
//   MAX_CODE full-scale wiper code; larger targets are clamped to it
//   TIMEOUT  clk cycles to wait for pot_ok before flagging err_tmo
//
// Ports
//   clk          system clock
//   rst_         asynchronous active-low reset
//   tgt_wr       one-cycle strobe: load tgt_data as the new target
//   tgt_data     requested wiper code
//   ramp_en      1 = step toward the target, 0 = single direct write
//   pot_dat      code presented to the SPI controller, held until the next write
//   pot_send     one-cycle write request to the SPI controller
//   pot_busy     SPI controller busy
//   pot_ok       SPI controller end-of-write strobe
//   cur_val      last code confirmed written
//   ramp_active  high while cur_val differs from the target or a write is in flight
//   err_tmo      sticky lost-completion flag, cleared by tgt_wr
module pot_ramp_seq #(
  parameter int unsigned STEP     = 1,
  parameter int unsigned DWELL    = 4000,
  parameter int unsigned MAX_CODE = 256,
  parameter int unsigned TIMEOUT  = 8191
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       tgt_wr,
  input  logic [8:0] tgt_data,
  input  logic       ramp_en,
  output logic [8:0] pot_dat,
  output logic       pot_send,
  input  logic       pot_busy,
  input  logic       pot_ok,
  output logic [8:0] cur_val,
  output logic       ramp_active,
  output logic       err_tmo
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_OK,
    S_DWELL
  } state_t;

  state_t        r_state;
  logic [8:0]    r_target;
  logic [8:0]    r_nxt;
  logic [8:0]    r_pot_dat;
  logic          r_pot_send;
  logic [8:0]    r_cur;
  logic          r_err;
  logic [TW-1:0] r_tmo_cnt;
  logic [DW-1:0] r_dwell_cnt;

  logic [8:0]    w_tgt_clamp;
  logic [9:0]    w_cur10;
  logic [9:0]    w_tgt10;
  logic [9:0]    w_step10;
  logic [9:0]    w_up10;
  logic [9:0]    w_dn10;
  logic [8:0]    w_nxt;

  assign w_tgt_clamp = ({1'b0, tgt_data} > 10'(MAX_CODE)) ? 9'(MAX_CODE) : tgt_data;

  // 10-bit arithmetic: the up step may exceed 9 bits and the down step is only
  // taken when it cannot underflow, so neither end wraps.
  assign w_cur10  = {1'b0, r_cur};
  assign w_tgt10  = {1'b0, r_target};
  assign w_step10 = 10'(STEP);
  assign w_up10   = w_cur10 + w_step10;
  assign w_dn10   = (w_cur10 >= w_step10) ? (w_cur10 - w_step10) : '0;

  always_comb begin
    w_nxt = r_target;
    if (ramp_en) begin
      if (w_tgt10 > w_cur10) begin
        w_nxt = (w_up10 >= w_tgt10) ? r_target : w_up10[8:0];
      end else begin
        w_nxt = ((w_cur10 < w_step10) || (w_dn10 <= w_tgt10)) ? r_target : w_dn10[8:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= S_IDLE;
      r_target    <= '0;
      r_nxt       <= '0;
      r_pot_dat   <= '0;
      r_pot_send  <= 1'b0;
      r_cur       <= '0;
      r_err       <= 1'b0;
      r_tmo_cnt   <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_pot_send <= 1'b0;

      // Target loads in any state; an in-flight write is left to finish.
      if (tgt_wr) begin
        r_target <= w_tgt_clamp;
        r_err    <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if ((r_target != r_cur) && !pot_busy) begin
            r_nxt   <= w_nxt;
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_pot_dat  <= r_nxt;
          r_pot_send <= 1'b1;
          r_tmo_cnt  <= '0;
          r_state    <= S_WAIT_OK;
        end

        // pot_ok is only honoured here, which drops the post-reset glitch.
        S_WAIT_OK: begin
          if (pot_ok) begin
            r_cur       <= r_pot_dat;
            r_dwell_cnt <= '0;
            r_state     <= S_DWELL;
          end else if (r_tmo_cnt == TW'(TIMEOUT)) begin
            // cur_val is left alone so IDLE re-issues the same step.
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end

        S_DWELL: begin
          if (!ramp_en || (r_dwell_cnt == DW'(DWELL - 1))) begin
            r_state <= S_IDLE;
          end else begin
            r_dwell_cnt <= r_dwell_cnt + DW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pot_dat     = r_pot_dat;
  assign pot_send    = r_pot_send;
  assign cur_val     = r_cur;
  assign err_tmo     = r_err;
  assign ramp_active = (r_state != S_IDLE) || (r_target != r_cur);

endmodule
